// File: rtl/i2c_poll_scheduler_pkg.sv
// Shared definitions for the I2C sensor poll scheduler.
//   poll_state_e   : scheduler FSM states
//   BACKOFF_CYCLES : dwell between a failed attempt and its retry
//   ERR_CNT_W      : width of the saturating failed-attempt counter
//   sat_inc        : saturating increment for the error counter
package i2c_poll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ISSUE,
    WAIT,
    BACKOFF,
    PUBLISH
  } poll_state_e;

  localparam int unsigned BACKOFF_CYCLES = 16;
  localparam int unsigned ERR_CNT_W      = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/i2c_poll_scheduler_timer.sv
// poll_timer: loadable up-counter with terminal-count flag.
//   clk, reset_n  : clock, synchronous active-low reset
//   load_i        : load load_val_i (takes priority over inc_i)
//   load_val_i    : value loaded by load_i
//   inc_i         : count up by one
//   term_i        : terminal value compared against the count
//   tc_o          : count equals term_i
module poll_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == term_i);

endmodule

// File: rtl/i2c_poll_scheduler.sv
// i2c_poll_scheduler: periodically starts I2C sensor reads, supervises each
// read with a timeout and bounded retries, and publishes the last good
// reading to the display consumers.
//   clk, reset_n     : 50 MHz clock, synchronous active-low reset
//   en               : polling enable
//   force_req        : request an immediate poll (honoured in ARMED only)
//   i2c_start        : one-cycle pulse starting one I2C read
//   i2c_busy         : I2C master transaction in progress
//   i2c_done         : one-cycle pulse when the transaction ends
//   i2c_ack_err      : qualifies i2c_done; 1 = NACK / bus error
//   i2c_rdata        : read data, valid in the i2c_done cycle
//   data             : last good reading
//   data_valid       : at least one good reading since reset
//   update           : one-cycle pulse when data changes value (or first valid)
//   fault            : last poll exhausted its retries; cleared by a good read
//   err_count        : failed attempts, saturating
module i2c_poll_scheduler
  import i2c_poll_pkg::*;
#(
  parameter int unsigned POLL_PERIOD    = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned DATA_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 force_req,
  output logic                 i2c_start,
  input  logic                 i2c_busy,
  input  logic                 i2c_done,
  input  logic                 i2c_ack_err,
  input  logic [DATA_W-1:0]    i2c_rdata,
  output logic [DATA_W-1:0]    data,
  output logic                 data_valid,
  output logic                 update,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned PW = $clog2(POLL_PERIOD);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES
                                                                   : BACKOFF_CYCLES;
  localparam int unsigned TW = $clog2(TMAX);

  poll_state_e            state_q, state_d;
  logic                   start_q;
  logic [DATA_W-1:0]      cap_q;
  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   update_q;
  logic                   fault_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic [3:0]             retry_q;

  logic                   per_tc;
  logic                   tmr_tc;
  logic [TW-1:0]          tmr_term;
  logic                   good_rd;
  logic                   bad_rd;
  logic                   can_retry;

  // Period counter only advances while ARMED and restarts from zero on every
  // entry, so the poll interval excludes transaction time.
  poll_timer #(.WIDTH(PW)) u_period (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (state_q != ARMED),
    .load_val_i ('0),
    .inc_i      (state_q == ARMED),
    .term_i     (PW'(POLL_PERIOD - 1)),
    .tc_o       (per_tc)
  );

  // One counter serves both WAIT (timeout) and BACKOFF; it is cleared on every
  // state change so each of those states starts counting from zero.
  assign tmr_term = (state_q == WAIT) ? TW'(TIMEOUT_CYCLES - 1) : TW'(BACKOFF_CYCLES - 1);

  poll_timer #(.WIDTH(TW)) u_timeout (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (state_d != state_q),
    .load_val_i ('0),
    .inc_i      ((state_q == WAIT) || (state_q == BACKOFF)),
    .term_i     (tmr_term),
    .tc_o       (tmr_tc)
  );

  assign can_retry = (retry_q < 4'(MAX_RETRIES));

  always_comb begin
    state_d = state_q;
    good_rd = 1'b0;
    bad_rd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = ISSUE;
      end
      ARMED: begin
        if (!en)                        state_d = IDLE;
        else if (per_tc || force_req)   state_d = ISSUE;
      end
      ISSUE: begin
        if (!i2c_busy) state_d = WAIT;
      end
      WAIT: begin
        // A done pulse in the timeout cycle still counts as a completed read.
        if (i2c_done && !i2c_ack_err) begin
          good_rd = 1'b1;
          state_d = PUBLISH;
        end else if (i2c_done || tmr_tc) begin
          bad_rd = 1'b1;
          if (can_retry) state_d = BACKOFF;
          else           state_d = en ? ARMED : IDLE;
        end
      end
      BACKOFF: begin
        if (tmr_tc) state_d = ISSUE;
      end
      PUBLISH: begin
        state_d = en ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      cap_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      fault_q  <= 1'b0;
      err_q    <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= (state_q == ISSUE) && !i2c_busy;
      update_q <= 1'b0;

      if (good_rd) cap_q <= i2c_rdata;

      if (bad_rd) begin
        err_q <= sat_inc(err_q);
        if (can_retry) begin
          retry_q <= retry_q + 1'b1;
        end else begin
          fault_q <= 1'b1;
          retry_q <= '0;
        end
      end

      if (state_q == PUBLISH) begin
        data_q   <= cap_q;
        valid_q  <= 1'b1;
        fault_q  <= 1'b0;
        retry_q  <= '0;
        update_q <= (cap_q != data_q) || !valid_q;
      end
    end
  end

  assign i2c_start  = start_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign update     = update_q;
  assign fault      = fault_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Directed bench for i2c_poll_scheduler with POLL_PERIOD=100,
// TIMEOUT_CYCLES=20, MAX_RETRIES=2. Inputs change 1 ns after a rising edge,
// outputs are sampled at the same point. Timing reference: a state entered at
// edge E; ARMED dwells 100 cycles, ISSUE 1 cycle, so i2c_start is seen after
// edge E+101 when E is the return to ARMED, and E+17 after a failed attempt.
module tb_i2c_poll_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        force_req;
  logic        i2c_start;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_ack_err;
  logic [15:0] i2c_rdata;
  logic [15:0] data;
  logic        data_valid;
  logic        update;
  logic        fault;
  logic [7:0]  err_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_poll_scheduler #(
    .POLL_PERIOD    (100),
    .TIMEOUT_CYCLES (20),
    .MAX_RETRIES    (2),
    .DATA_W         (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .force_req   (force_req),
    .i2c_start   (i2c_start),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .i2c_ack_err (i2c_ack_err),
    .i2c_rdata   (i2c_rdata),
    .data        (data),
    .data_valid  (data_valid),
    .update      (update),
    .fault       (fault),
    .err_count   (err_count)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start must be low for n-1 edges and high on the n-th.
  task automatic expect_start_after(input int n, input string tag);
    cyc(n - 1);
    chk({tag, "_early"}, {31'd0, i2c_start}, 32'd0);
    cyc(1);
    chk(tag, {31'd0, i2c_start}, 32'd1);
  endtask

  // One-cycle done pulse from the I2C master model.
  task automatic do_done(input logic [15:0] d, input logic e);
    i2c_done    = 1'b1;
    i2c_ack_err = e;
    i2c_rdata   = d;
    cyc(1);
    i2c_done    = 1'b0;
    i2c_ack_err = 1'b0;
    i2c_rdata   = 16'h0000;
  endtask

  task automatic wait_start(input int bound);
    logic found;
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      cyc(1);
      if (i2c_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("start_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int nstart;
    reset_n     = 1'b0;
    en          = 1'b0;
    force_req   = 1'b0;
    i2c_busy    = 1'b0;
    i2c_done    = 1'b0;
    i2c_ack_err = 1'b0;
    i2c_rdata   = 16'h0000;

    // ---- 1: reset state, first poll, publish latency, period
    cyc(3);
    chk("rst_start", {31'd0, i2c_start}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_no_start", {31'd0, i2c_start}, 32'd0);
    en = 1'b1;
    expect_start_after(2, "first_start");
    cyc(1);
    chk("start_one_pulse", {31'd0, i2c_start}, 32'd0);
    cyc(8);
    do_done(16'h1A2B, 1'b0);
    chk("data_not_yet", {16'd0, data}, 32'd0);
    cyc(1);
    chk("p1_data", {16'd0, data}, 32'h1A2B);
    chk("p1_update", {31'd0, update}, 32'd1);
    chk("p1_valid", {31'd0, data_valid}, 32'd1);
    cyc(1);
    chk("p1_update_pulse", {31'd0, update}, 32'd0);
    expect_start_after(100, "p2_start");

    // ---- 2: unchanged value -> no update; changed value -> update
    cyc(4);
    do_done(16'h1A2B, 1'b0);
    cyc(1);
    chk("p2_no_update", {31'd0, update}, 32'd0);
    chk("p2_data", {16'd0, data}, 32'h1A2B);
    expect_start_after(101, "p3_start");
    cyc(4);
    do_done(16'h1A2C, 1'b0);
    cyc(1);
    chk("p3_data", {16'd0, data}, 32'h1A2C);
    chk("p3_update", {31'd0, update}, 32'd1);
    cyc(1);
    chk("p3_update_pulse", {31'd0, update}, 32'd0);

    // ---- 3: three NACKs -> backoff retries, fault, data held
    expect_start_after(100, "nack1_start");
    cyc(2);
    do_done(16'hFFFF, 1'b1);
    chk("nack1_err", {24'd0, err_count}, 32'd1);
    chk("nack1_fault", {31'd0, fault}, 32'd0);
    expect_start_after(17, "nack2_start");
    cyc(2);
    do_done(16'hFFFF, 1'b1);
    chk("nack2_err", {24'd0, err_count}, 32'd2);
    expect_start_after(17, "nack3_start");
    cyc(2);
    do_done(16'hFFFF, 1'b1);
    chk("nack3_err", {24'd0, err_count}, 32'd3);
    chk("nack3_fault", {31'd0, fault}, 32'd1);
    chk("nack3_data", {16'd0, data}, 32'h1A2C);
    chk("nack3_valid", {31'd0, data_valid}, 32'd1);
    expect_start_after(101, "after_fault_start");
    cyc(2);
    do_done(16'h1A2C, 1'b0);
    cyc(1);
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_clr_no_update", {31'd0, update}, 32'd0);

    // ---- 4: timeout abort, done in abort cycle, done after abort
    expect_start_after(101, "to1_start");
    cyc(19);
    chk("to1_before_abort", {24'd0, err_count}, 32'd3);
    cyc(1);
    chk("to1_abort", {24'd0, err_count}, 32'd4);
    expect_start_after(17, "to2_start");
    cyc(19);
    do_done(16'h5A5A, 1'b0);
    cyc(1);
    chk("to2_done_wins_data", {16'd0, data}, 32'h5A5A);
    chk("to2_done_wins_update", {31'd0, update}, 32'd1);
    chk("to2_done_wins_err", {24'd0, err_count}, 32'd4);
    expect_start_after(101, "to3_start");
    cyc(20);
    chk("to3_abort", {24'd0, err_count}, 32'd5);
    do_done(16'hBEEF, 1'b0);
    cyc(1);
    chk("late_done_ignored", {16'd0, data}, 32'h5A5A);
    chk("late_done_no_update", {31'd0, update}, 32'd0);
    expect_start_after(15, "to3_retry_start");
    cyc(2);
    do_done(16'h5A5A, 1'b0);
    cyc(1);
    chk("to3_retry_no_update", {31'd0, update}, 32'd0);

    // ---- 5: busy at tick, force_req in ARMED and in WAIT
    i2c_busy = 1'b1;
    nstart = 0;
    for (int i = 0; i < 130; i++) begin
      cyc(1);
      if (i2c_start === 1'b1) nstart++;
    end
    chk("busy_no_start", nstart, 32'd0);
    i2c_busy = 1'b0;
    cyc(1);
    chk("busy_release_start", {31'd0, i2c_start}, 32'd1);
    cyc(1);
    chk("busy_release_one_pulse", {31'd0, i2c_start}, 32'd0);
    do_done(16'h5A5A, 1'b0);
    cyc(1);
    cyc(40);
    force_req = 1'b1;
    cyc(1);
    force_req = 1'b0;
    chk("force_issue_no_start", {31'd0, i2c_start}, 32'd0);
    cyc(1);
    chk("force_start", {31'd0, i2c_start}, 32'd1);
    force_req = 1'b1;
    nstart = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (i2c_start === 1'b1) nstart++;
    end
    force_req = 1'b0;
    chk("force_in_wait_ignored", nstart, 32'd0);
    do_done(16'h5A5A, 1'b0);
    cyc(1);
    expect_start_after(101, "force_not_queued");

    // ---- 6: reset mid-WAIT, stray done in IDLE, err_count saturation
    cyc(3);
    reset_n = 1'b0;
    en      = 1'b0;
    cyc(1);
    chk("midrst_start", {31'd0, i2c_start}, 32'd0);
    chk("midrst_data", {16'd0, data}, 32'd0);
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    chk("midrst_update", {31'd0, update}, 32'd0);
    chk("midrst_fault", {31'd0, fault}, 32'd0);
    chk("midrst_err", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    cyc(1);
    do_done(16'hDEAD, 1'b0);
    cyc(2);
    chk("stray_done_data", {16'd0, data}, 32'd0);
    chk("stray_done_valid", {31'd0, data_valid}, 32'd0);
    chk("stray_done_no_start", {31'd0, i2c_start}, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 260; i++) begin
      wait_start(200);
      do_done(16'h0000, 1'b1);
      if (i == 253) chk("err_254", {24'd0, err_count}, 32'd254);
      if (i == 254) chk("err_255", {24'd0, err_count}, 32'd255);
    end
    chk("err_saturated", {24'd0, err_count}, 32'd255);
    chk("sat_data_held", {16'd0, data}, 32'd0);
    chk("sat_valid", {31'd0, data_valid}, 32'd0);
    en = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
